// File: rtl/lif_neuron_array.sv
// Layer of leaky integrate-and-fire neurons. All neurons share one input spike vector that
// arrives as a byte stream. Per-neuron weights and signs, and the global parameters, are set through a byte-wide register port.
//
// state   | meaning
// COLLECT | accepting input bytes into the frame shift register
// UPDATE  | single cycle: every neuron integrates the assembled frame
module lif_neuron_array #(
  parameter int N_NEURONS  = 4,
  parameter int INPUTS     = 16,
  parameter int U_WIDTH    = 8,
  parameter int REF_WIDTH  = 3,
  parameter int ADDR_WIDTH = 8,
  localparam int SEL_W     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  input  logic                  cfg_we,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [7:0]            cfg_data,
  input  logic [SEL_W-1:0]      mon_sel,
  output logic [N_NEURONS-1:0]  spikes,
  output logic                  out_valid,
  output logic [U_WIDTH-1:0]    mon_u
);

  localparam int B  = INPUTS / 8;
  localparam int BW = (B > 1) ? $clog2(B) : 1;
  localparam int PW = $clog2(INPUTS + 1);
  localparam int EW = U_WIDTH + PW + 2;
  localparam int G  = N_NEURONS * 2 * B;
  localparam logic [ADDR_WIDTH-1:0] A_THETA   = ADDR_WIDTH'(G);
  localparam logic [ADDR_WIDTH-1:0] A_SHIFT   = ADDR_WIDTH'(G + 1);
  localparam logic [ADDR_WIDTH-1:0] A_REFRACT = ADDR_WIDTH'(G + 2);
  localparam logic [ADDR_WIDTH-1:0] A_CLEAR   = ADDR_WIDTH'(G + 3);
  localparam logic signed [EW-1:0]  VMAX      = EW'((1 << (U_WIDTH - 1)) - 1);
  localparam logic signed [EW-1:0]  VMIN      = ~VMAX;

  typedef enum logic {COLLECT, UPDATE} state_t;
  state_t state, state_next;

  logic [INPUTS-1:0]         w [N_NEURONS];
  logic [INPUTS-1:0]         s [N_NEURONS];
  logic [7:0]                theta;
  logic [2:0]                shift;
  logic [REF_WIDTH-1:0]      refract;
  logic [INPUTS-1:0]         x;
  logic [BW-1:0]             byte_cnt;
  logic signed [U_WIDTH-1:0] u [N_NEURONS];
  logic [REF_WIDTH-1:0]      rc [N_NEURONS];

  logic                      in_fire, last_byte, clear;
  logic signed [U_WIDTH-1:0] leak [N_NEURONS];
  logic signed [EW-1:0]      syn [N_NEURONS];
  logic signed [EW-1:0]      acc [N_NEURONS];
  logic signed [EW-1:0]      v [N_NEURONS];
  logic signed [EW-1:0]      theta_e;
  logic [N_NEURONS-1:0]      fire;

  function automatic logic [PW-1:0] popcount(input logic [INPUTS-1:0] d);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < INPUTS; i++) c = c + PW'(d[i]);
    return c;
  endfunction

  assign in_fire   = in_valid && in_ready;
  assign last_byte = (byte_cnt == BW'(B - 1));
  assign clear     = cfg_we && (cfg_addr == A_CLEAR);
  assign theta_e   = EW'(theta);
  assign mon_u     = u[mon_sel];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= COLLECT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid && last_byte) state_next = UPDATE;
      end
      UPDATE:  state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  // First byte of a frame ends up in the MSBs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x        <= '0;
      byte_cnt <= '0;
    end else if (in_fire) begin
      x        <= (x << 8) | INPUTS'(in_data);
      byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < N_NEURONS; n++) begin
        w[n] <= '0;
        s[n] <= '0;
      end
      theta   <= 8'd5;
      shift   <= '0;
      refract <= '0;
    end else if (cfg_we) begin
      for (int n = 0; n < N_NEURONS; n++) begin
        for (int j = 0; j < B; j++) begin
          if (cfg_addr == ADDR_WIDTH'(n * 2 * B + j))     w[n][8*j +: 8] <= cfg_data;
          if (cfg_addr == ADDR_WIDTH'(n * 2 * B + B + j)) s[n][8*j +: 8] <= cfg_data;
        end
      end
      if (cfg_addr == A_THETA)   theta   <= cfg_data;
      if (cfg_addr == A_SHIFT)   shift   <= cfg_data[2:0];
      if (cfg_addr == A_REFRACT) refract <= cfg_data[REF_WIDTH-1:0];
    end
  end

  // Wide accumulator keeps u - leak + syn exact before saturating back to U_WIDTH.
  always_comb begin
    for (int n = 0; n < N_NEURONS; n++) begin
      if (shift == 3'd0) leak[n] = '0;
      else               leak[n] = u[n] >>> shift;
      syn[n] = '0;
      if (rc[n] == '0)
        syn[n] = EW'(popcount(x & w[n] & ~s[n])) - EW'(popcount(x & w[n] & s[n]));
      acc[n] = EW'(u[n]) - EW'(leak[n]) + syn[n];
      if (acc[n] > VMAX)      v[n] = VMAX;
      else if (acc[n] < VMIN) v[n] = VMIN;
      else                    v[n] = acc[n];
      fire[n] = (rc[n] == '0) && (v[n] >= theta_e);
    end
  end

  // A CLEAR landing in the UPDATE cycle overrides the membrane update but not the spike output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < N_NEURONS; n++) begin
        u[n]  <= '0;
        rc[n] <= '0;
      end
      spikes    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= (state == UPDATE);
      if (state == UPDATE) spikes <= fire;
      for (int n = 0; n < N_NEURONS; n++) begin
        if (clear) begin
          u[n]  <= '0;
          rc[n] <= '0;
        end else if (state == UPDATE) begin
          if (fire[n]) begin
            u[n]  <= U_WIDTH'(v[n] - theta_e);
            rc[n] <= refract;
          end else begin
            u[n] <= U_WIDTH'(v[n]);
            if (rc[n] != '0) rc[n] <= rc[n] - 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Bench for lif_neuron_array: table of frames with expected neuron-0 results checked through
// a scoreboard, plus hand sequences for CLEAR-during-update and mid-frame reset.
module tb_lif_neuron_array;

  localparam int G = 16;

  logic       clk, reset, in_valid, in_ready, cfg_we, out_valid;
  logic [7:0] in_data, cfg_addr, cfg_data, mon_u;
  logic [1:0] mon_sel;
  logic [3:0] spikes;

  int vectors = 0;
  int miscompares = 0;
  int nframe = 0;

  typedef struct {
    int         phase;
    logic [15:0] frame;
    logic [3:0] spk;
    int         u;
  } vec_t;

  typedef struct {
    logic [3:0] spk;
    int         u;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];

  lif_neuron_array dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .mon_sel(mon_sel),
    .spikes(spikes), .out_valid(out_valid), .mon_u(mon_u)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && out_valid) begin
      nframe++;
      if (sbq.size() == 0) begin
        check($sformatf("frame%0d unexpected out_valid", nframe), 1, 0);
      end else begin
        e = sbq.pop_front();
        check($sformatf("frame%0d spikes", nframe), int'(spikes), int'(e.spk));
        check($sformatf("frame%0d mon_u", nframe), int'($signed(mon_u)), e.u);
      end
    end
  end

  task automatic cfg_wr(input int a, input int d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 8'(a); cfg_data = 8'(d);
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("in_ready timeout", 0, 1);
    in_valid = 1'b1; in_data = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] f, input logic [3:0] spk, input int u);
    sbq.push_back('{spk, u});
    send_byte(f[15:8]);
    send_byte(f[7:0]);
    @(negedge clk);
    check("in_ready in update", int'(in_ready), 0);
    check("out_valid in update", int'(out_valid), 0);
  endtask

  task automatic drain();
    int guard = 0;
    while (sbq.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("scoreboard drained", sbq.size(), 0);
    sbq.delete();
  endtask

  task automatic setup(input int ph);
    drain();
    case (ph)
      1: begin cfg_wr(0, 8'hFF); cfg_wr(1, 8'hFF); end
      2: begin cfg_wr(G + 1, 2); cfg_wr(G, 100); cfg_wr(G + 3, 0); end
      3: begin cfg_wr(2, 8'hFF); cfg_wr(3, 8'hFF); cfg_wr(G + 1, 0); cfg_wr(G + 3, 0); end
      4: begin cfg_wr(2, 0); cfg_wr(3, 0); cfg_wr(G + 2, 2); cfg_wr(G, 5); cfg_wr(G + 3, 0); end
      5: begin cfg_wr(G + 2, 0); cfg_wr(G, 200); cfg_wr(G + 3, 0); end
      default: ;
    endcase
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    int val;
    int p2[9];
    p2 = '{4, 7, 10, 12, 13, 14, 15, 16, 16};

    tbl.push_back('{1, 16'hFFFF, 4'b0001, 11});
    tbl.push_back('{1, 16'h0000, 4'b0001, 6});
    tbl.push_back('{1, 16'h0000, 4'b0001, 1});
    tbl.push_back('{1, 16'h0000, 4'b0000, 1});
    for (int k = 0; k < 9; k++) tbl.push_back('{2, 16'h000F, 4'b0000, p2[k]});
    for (int k = 1; k <= 9; k++) begin
      val = -16 * k;
      if (val < -128) val = -128;
      tbl.push_back('{3, 16'hFFFF, 4'b0000, val});
    end
    tbl.push_back('{4, 16'hFFFF, 4'b0001, 11});
    tbl.push_back('{4, 16'hFFFF, 4'b0000, 11});
    tbl.push_back('{4, 16'hFFFF, 4'b0000, 11});
    tbl.push_back('{4, 16'hFFFF, 4'b0001, 22});
    for (int k = 1; k <= 9; k++) begin
      val = 16 * k;
      if (val > 127) val = 127;
      tbl.push_back('{5, 16'hFFFF, 4'b0000, val});
    end

    reset = 1'b1; in_valid = 1'b0; in_data = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; mon_sel = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    check("reset spikes", int'(spikes), 0);
    check("reset out_valid", int'(out_valid), 0);
    check("reset in_ready", int'(in_ready), 1);
    for (int i = 0; i < 4; i++) begin
      mon_sel = 2'(i);
      #1 check($sformatf("reset mon_u[%0d]", i), int'(mon_u), 0);
    end
    mon_sel = '0;

    prev = 0;
    foreach (tbl[i]) begin
      if (tbl[i].phase != prev) begin
        setup(tbl[i].phase);
        prev = tbl[i].phase;
      end
      send_frame(tbl[i].frame, tbl[i].spk, tbl[i].u);
    end

    // CLEAR written in the UPDATE cycle: spike from old state, u and rc zeroed
    drain();
    cfg_wr(G, 5);
    cfg_wr(G + 2, 2);
    sbq.push_back('{4'b0001, 0});
    send_byte(8'hFF);
    send_byte(8'hFF);
    cfg_we = 1'b1; cfg_addr = 8'(G + 3); cfg_data = 8'h00;
    @(posedge clk);
    #1 cfg_we = 1'b0;
    send_frame(16'hFFFF, 4'b0001, 11);

    // reset after the first byte of a frame: no result, next frame assembles from scratch
    drain();
    send_byte(8'hAB);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("post-reset spikes", int'(spikes), 0);
    check("post-reset in_ready", int'(in_ready), 1);
    repeat (4) @(negedge clk);
    cfg_wr(1, 8'hFF);
    cfg_wr(4, 8'hFF);
    send_frame(16'hFF00, 4'b0001, 3);
    drain();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lif_neuron_array.md
# lif_neuron_array

Parametrised layer of leaky integrate-and-fire neurons that all share one binary input spike vector. Each neuron has its own binary weight mask and inhibitory sign mask, a shift-based leak, a threshold with reset-by-subtraction, saturating membrane arithmetic and a programmable refractory period. The input spike vector arrives as bytes over a valid/ready stream; a byte-wide register port holds the configuration. The block is the next-generation core for the tile's top level and replaces the single-neuron datapath.

## Interface
- `N_NEURONS`, 4: number of neurons updated in parallel.
- `INPUTS`, 16: input vector width. Must be a multiple of 8. B = INPUTS/8 bytes per frame.
- `U_WIDTH`, 8: signed membrane width. Range 8..16.
- `REF_WIDTH`, 3: refractory counter width.
- `ADDR_WIDTH`, 8: config address width.
- `clk` in 1: clock. All state changes on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `in_valid` in 1: input byte valid.
- `in_data` in 8: input spike byte.
- `in_ready` out 1: block accepts a byte when both `in_valid` and `in_ready` are high.
- `cfg_we` in 1: config write strobe.
- `cfg_addr` in ADDR_WIDTH: config address.
- `cfg_data` in 8: config write data.
- `mon_sel` in clog2(N_NEURONS): selects the neuron for the membrane monitor.
- `spikes` out N_NEURONS: registered spike vector from the last update.
- `out_valid` out 1: one-cycle pulse when a new update result is present.
- `mon_u` out U_WIDTH: membrane value of neuron `mon_sel`. Combinational read of the register.

## Operation
- Config map, with n = neuron index and j = byte index 0..B-1:
  - weight byte j of neuron n at n·2B+j.
  - sign byte j of neuron n at n·2B+B+j.
  - G = N_NEURONS·2B. THETA at G, SHIFT at G+1 (bits [2:0]), REFRACT at G+2 (bits [REF_WIDTH-1:0]), CLEAR at G+3.
  - Writes to other addresses are ignored.
  - Byte j maps to bits [8j+7:8j].
- Writing CLEAR (any data) zeroes all u and all refractory counters. It does not touch the partially assembled frame.
- Frame assembly: each accepted byte updates `x <= {x[INPUTS-9:0], in_data}`, so the first byte lands in the MSBs. A byte counter runs 0..B-1.
- FSM:
  - COLLECT: `in_ready`=1. Accepting byte B-1 clears the counter and moves to UPDATE.
  - UPDATE: lasts exactly 1 cycle, `in_ready`=0. All neurons update, `spikes` is loaded, `out_valid`<=1, then the FSM returns to COLLECT.
- Per-neuron update, using the old u:
  - leak = (SHIFT==0) ? 0 : u>>>SHIFT (arithmetic shift).
  - syn = popcount(x & w & ~s) − popcount(x & w & s).
  - If the refractory counter rc>0, then syn=0.
  - v = sat(u − leak + syn), computed at full width and saturated to [−2^(U_WIDTH−1), 2^(U_WIDTH−1)−1].
  - Spike = (rc==0) && (v ≥ THETA). THETA is zero-extended and compared as signed. THETA ≥ 2^(U_WIDTH−1) never fires.
  - On spike: u <= v − THETA and rc <= REFRACT.
  - Otherwise: u <= v, and rc <= rc−1 if rc>0.
- Simultaneous events:
  - A CLEAR write in the UPDATE cycle wins: u=0, rc=0, and `spikes` is still computed from the old state.
  - Any other config write in the UPDATE cycle is applied after that update, which uses the old values.
- Reset values: u=0, rc=0, w=0, s=0, THETA=5, SHIFT=0, REFRACT=0, x=0, counter=0, state=COLLECT, `spikes`=0, `out_valid`=0, `in_ready`=1.
- Reset asserted mid-frame or mid-update discards everything. No `out_valid` is produced for the interrupted frame.

## Timing
- Byte accepted at rising edge t. If it is the last byte, the state is UPDATE during cycle t..t+1 and `in_ready` is 0.
- At edge t+1: u, rc and `spikes` are registered and `out_valid` goes 1 for exactly the cycle t+1..t+2. `in_ready` is 1 again in that cycle.
- Throughput: one frame per B+1 cycles at full rate.
- `spikes` holds until the next UPDATE.
- A config write takes effect at the edge where `cfg_we` is sampled.
- `mon_u` reflects the register value with no added latency.

## Test plan
- Reset: drive `in_valid` low. All outputs hold reset values, `in_ready`=1, and `mon_u`=0 for every `mon_sel`.
- Neuron 0 setup: weights 0xFF,0xFF, s=0, THETA=5, SHIFT=0. Send frame 0xFF,0xFF, then three frames 0x00,0x00.
  - `spikes[0]` = 1,1,1,0.
  - `mon_u` = 11,6,1,1.
  - `out_valid` pulses once per frame, one cycle after the last byte. `in_ready` is low for exactly 1 cycle per frame.
- Leak: SHIFT=2, THETA=100. Repeat frame 0x00,0x0F.
  - u = 4,7,10,12,13,14,15,16,16.
  - No spikes.
- Inhibition and saturation: w=s=0xFFFF. Repeat frame 0xFF,0xFF.
  - u = −16,−32,…,−128 after 8 frames.
  - The 9th frame stays at −128.
- Refractory: REFRACT=2, THETA=5, w=0xFFFF. Send four frames 0xFF,0xFF.
  - spikes = 1,0,0,1.
  - u = 11,11,11,22.
- Concurrency:
  - Write CLEAR in the UPDATE cycle: `spikes` still reflects the update, and u=0 afterward.
  - Assert `reset` after byte 0 of a frame: no `out_valid`. The next full frame is assembled correctly from the reset state.
